// File: rtl/instr_issue_buffer_pkg.sv
// Purpose : shared types for the instruction issue buffer (packet layout, enums, idle value).
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package instr_issue_pkg;

    // Address/immediate width and register index width of an issue packet.
    localparam int XLEN      = 32;
    localparam int REG_W     = 6;
    // Widest lane vector the helper functions handle (ISSUE_WIDTH is 1..4).
    localparam int MAX_LANES = 4;

    typedef enum logic [2:0] {
        UNKNOWN = 3'd0,
        ADD     = 3'd1,
        SUB     = 3'd2,
        ADDI    = 3'd3,
        LW      = 3'd4,
        SW      = 3'd5,
        BEQ     = 3'd6,
        JAL     = 3'd7
    } instr_name_e;

    typedef enum logic [1:0] {
        XX   = 2'd0,
        ST_B = 2'd1,
        ST_H = 2'd2,
        ST_W = 2'd3
    } st_type_e;

    typedef struct packed {
        logic [XLEN-1:0]  address;
        logic [XLEN-1:0]  immediate;
        logic [REG_W-1:0] src_1;
        logic [REG_W-1:0] src_2;
        logic [REG_W-1:0] arn;
        logic [REG_W-1:0] rrn;
        logic             jump;
        logic             tag;
        instr_name_e      instr_name;
        st_type_e         st_type;
    } issue_pkt_t;

    // Value presented on an output lane that carries no valid entry.
    localparam issue_pkt_t ISSUE_IDLE = '{
        address:    '0,
        immediate:  '0,
        src_1:      '0,
        src_2:      '0,
        arn:        '0,
        rrn:        '0,
        jump:       1'b0,
        tag:        1'b0,
        instr_name: UNKNOWN,
        st_type:    XX
    };

    // Number of consecutive set bits starting at lane 0, looking at the
    // first 'lanes' lanes only. A gap stops the count.
    function automatic int leading_ones(input logic [MAX_LANES-1:0] v, input int lanes);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (run && (i < lanes) && v[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/instr_issue_buffer_ring_store.sv
// Purpose : DEPTH-entry packet storage, ISSUE_WIDTH write ports, ISSUE_WIDTH read ports, per-entry tag clear.
// Latency : writes visible on the read ports the cycle after the write edge; reads are combinational.
// Backpressure: none here; the controlling block decides which ports are enabled.
//
// Ports: clk/rst (async active-high); wr_en/wr_idx/wr_pkt per write lane;
//        rd_idx -> rd_pkt per read lane; tag_clr clears the tag bit of the selected entries.
module issue_ring_store
    import instr_issue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ISSUE_WIDTH = 2,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ISSUE_WIDTH-1:0]              wr_en,
    input  logic [ISSUE_WIDTH-1:0][PTR_W-1:0]   wr_idx,
    input  issue_pkt_t [ISSUE_WIDTH-1:0]        wr_pkt,
    input  logic [ISSUE_WIDTH-1:0][PTR_W-1:0]   rd_idx,
    output issue_pkt_t [ISSUE_WIDTH-1:0]        rd_pkt,
    input  logic [DEPTH-1:0]                    tag_clr
);

    issue_pkt_t mem [DEPTH];

    // Tag clears are applied first so that a packet written into the same
    // entry in the same cycle keeps the tag it was written with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= ISSUE_IDLE;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (tag_clr[e]) begin
                    mem[e].tag <= 1'b0;
                end
            end
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (wr_en[k]) begin
                    mem[wr_idx[k]] <= wr_pkt[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_pkt[k] = mem[rd_idx[k]];
        end
    end

endmodule

// File: rtl/instr_issue_buffer.sv
// Purpose : in-order multi-lane issue buffer between dispatch and the ROB side, with speculative flush/commit.
// Latency : 1 cycle from push to visibility on out_pkt; pops take effect at the next edge.
// Backpressure: in_ready drops when fewer than ISSUE_WIDTH free entries remain (same-cycle pops not credited).
//
// Ports: clk, reset (async active-high); in_valid/in_pkt/in_ready push side;
//        out_valid/out_pkt/out_ready pop side (lane 0 oldest); flush_spec drops tagged
//        entries, commit_spec clears all tags, clear empties; count/empty/full status.
module instr_issue_buffer
    import instr_issue_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ISSUE_WIDTH-1:0]       in_valid,
    input  issue_pkt_t [ISSUE_WIDTH-1:0] in_pkt,
    output logic                         in_ready,
    output logic [ISSUE_WIDTH-1:0]       out_valid,
    output issue_pkt_t [ISSUE_WIDTH-1:0] out_pkt,
    input  logic [ISSUE_WIDTH-1:0]       out_ready,
    input  logic                         flush_spec,
    input  logic                         commit_spec,
    input  logic                         clear,
    output logic [CNT_W-1:0]             count,
    output logic                         empty,
    output logic                         full
);

    logic [PTR_W-1:0]                  head;
    logic [PTR_W-1:0]                  tail;
    logic [CNT_W-1:0]                  spec_count;

    logic                              push_ok;
    logic [CNT_W-1:0]                  n_push;
    logic [CNT_W-1:0]                  n_push_tag;
    logic [CNT_W-1:0]                  n_pop;
    logic [CNT_W-1:0]                  n_pop_tag;
    logic [ISSUE_WIDTH-1:0]            pop_mask;

    logic [ISSUE_WIDTH-1:0]            wr_en;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] wr_idx;
    issue_pkt_t [ISSUE_WIDTH-1:0]      wr_pkt;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] rd_idx;
    issue_pkt_t [ISSUE_WIDTH-1:0]      rd_pkt;
    logic [DEPTH-1:0]                  tag_clr;

    issue_ring_store #(
        .DEPTH       (DEPTH),
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_store (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_pkt  (wr_pkt),
        .rd_idx  (rd_idx),
        .rd_pkt  (rd_pkt),
        .tag_clr (tag_clr)
    );

    // Status derived from registered state only.
    always_comb begin
        in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(ISSUE_WIDTH);
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
    end

    // Push side: accept the leading run of valid lanes, only when a whole
    // group fits and no flush/clear is in progress. A commit in the same
    // cycle means the new packets are already non-speculative.
    always_comb begin
        push_ok    = in_ready && !flush_spec && !clear;
        n_push     = push_ok ? CNT_W'(leading_ones(MAX_LANES'(in_valid), ISSUE_WIDTH)) : '0;
        n_push_tag = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            wr_en[k]      = CNT_W'(k) < n_push;
            wr_idx[k]     = tail + PTR_W'(k);
            wr_pkt[k]     = in_pkt[k];
            wr_pkt[k].tag = in_pkt[k].tag && !commit_spec;
            if (wr_en[k] && wr_pkt[k].tag) begin
                n_push_tag = n_push_tag + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_idx[k] = head + PTR_W'(k);
        end
    end

    // Pop side: during a flush, lanes holding tagged entries are hidden so
    // only the surviving (untagged) entries can leave.
    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            out_valid[k] = (count > CNT_W'(k)) && !(flush_spec && rd_pkt[k].tag);
            out_pkt[k]   = out_valid[k] ? rd_pkt[k] : ISSUE_IDLE;
        end
        n_pop     = clear ? '0
                          : CNT_W'(leading_ones(MAX_LANES'(out_valid & out_ready), ISSUE_WIDTH));
        n_pop_tag = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            pop_mask[k] = CNT_W'(k) < n_pop;
            if (pop_mask[k] && rd_pkt[k].tag) begin
                n_pop_tag = n_pop_tag + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tag_clr = {DEPTH{commit_spec && !flush_spec && !clear}};
    end

    // Tagged entries always form the youngest block, so a flush is just a
    // rewind of tail by spec_count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            spec_count <= '0;
        end else if (clear) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            spec_count <= '0;
        end else if (flush_spec) begin
            head       <= head + PTR_W'(n_pop);
            tail       <= tail - PTR_W'(spec_count);
            count      <= count - n_pop - spec_count;
            spec_count <= '0;
        end else begin
            head       <= head + PTR_W'(n_pop);
            tail       <= tail + PTR_W'(n_push);
            count      <= count + n_push - n_pop;
            spec_count <= commit_spec ? '0 : (spec_count + n_push_tag - n_pop_tag);
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (count <= CNT_W'(DEPTH))
                else $error("instr_issue_buffer: count %0d exceeds depth", count);
            assert (spec_count <= count)
                else $error("instr_issue_buffer: spec_count %0d above count %0d", spec_count, count);
            assert ((pop_mask & ~out_valid) == '0)
                else $error("instr_issue_buffer: pop on a lane without out_valid");
            assert (!(flush_spec && commit_spec))
                else $error("instr_issue_buffer: flush_spec and commit_spec together, flush wins");
        end
    end

endmodule

// File: tb/tb_instr_issue_buffer.sv
// Purpose : self-checking bench for instr_issue_buffer against a queue-based reference model.
// Latency : checks combinational outputs each cycle before the edge, model advances at the edge.
// Backpressure: exercised through random and directed out_ready patterns.
module tb_instr_issue_buffer;
    import instr_issue_pkg::*;

    localparam int W = 2;
    localparam int D = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [W-1:0]         in_valid;
    issue_pkt_t [W-1:0]   in_pkt;
    logic                 in_ready;
    logic [W-1:0]         out_valid;
    issue_pkt_t [W-1:0]   out_pkt;
    logic [W-1:0]         out_ready;
    logic                 flush_spec;
    logic                 commit_spec;
    logic                 clear;
    logic [3:0]           count;
    logic                 empty;
    logic                 full;

    int checks = 0;
    int errors = 0;
    issue_pkt_t q[$];
    bit spec_mode = 1'b0;

    always #5 clk = ~clk;

    instr_issue_buffer #(.ISSUE_WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pkt      (in_pkt),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pkt     (out_pkt),
        .out_ready   (out_ready),
        .flush_spec  (flush_spec),
        .commit_spec (commit_spec),
        .clear       (clear),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic issue_pkt_t rand_pkt(input bit tg);
        issue_pkt_t p;
        p.address    = $urandom;
        p.immediate  = $urandom;
        p.src_1      = REG_W'($urandom);
        p.src_2      = REG_W'($urandom);
        p.arn        = REG_W'($urandom);
        p.rrn        = REG_W'($urandom);
        p.jump       = 1'($urandom);
        p.tag        = tg;
        p.instr_name = instr_name_e'($urandom_range(1, 7));
        p.st_type    = st_type_e'($urandom_range(0, 3));
        return p;
    endfunction

    // Expected outputs straight from the queue contents.
    task automatic check_outputs(input string where);
        bit         ev;
        issue_pkt_t ep;
        int         n;
        n = q.size();
        chk({where, ".in_ready"}, in_ready, (D - n) >= W);
        for (int k = 0; k < W; k++) begin
            ev = (k < n) && !(flush_spec && q[k].tag);
            ep = ev ? q[k] : ISSUE_IDLE;
            chk($sformatf("%s.out_valid%0d", where, k), out_valid[k], ev);
            chk($sformatf("%s.out_pkt%0d", where, k), out_pkt[k], ep);
        end
        chk({where, ".count"}, count, n);
        chk({where, ".empty"}, empty, n == 0);
        chk({where, ".full"}, full, n == D);
    endtask

    // One clock of buffer behaviour, expressed on the queue of stored packets.
    task automatic model_update();
        int         n_pop;
        int         n_push;
        int         n;
        issue_pkt_t p;
        issue_pkt_t keep[$];
        if (clear) begin
            q.delete();
            return;
        end
        n      = q.size();
        n_pop  = 0;
        n_push = 0;
        for (int k = 0; k < W; k++) begin
            if (k < n && !(flush_spec && q[k].tag) && out_ready[k] && n_pop == k) n_pop++;
        end
        if (((D - n) >= W) && !flush_spec) begin
            for (int k = 0; k < W; k++) begin
                if (in_valid[k] && n_push == k) n_push++;
            end
        end
        for (int i = 0; i < n_pop; i++) void'(q.pop_front());
        if (flush_spec) begin
            foreach (q[i]) if (!q[i].tag) keep.push_back(q[i]);
            q = keep;
        end else if (commit_spec) begin
            foreach (q[i]) q[i].tag = 1'b0;
        end
        for (int k = 0; k < n_push; k++) begin
            p = in_pkt[k];
            if (commit_spec) p.tag = 1'b0;
            q.push_back(p);
        end
    endtask

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] r, input bit tg,
                         input bit fl, input bit cm, input bit cl);
        in_valid    = v;
        out_ready   = r;
        flush_spec  = fl;
        commit_spec = cm;
        clear       = cl;
        for (int k = 0; k < W; k++) in_pkt[k] = rand_pkt(tg);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string where);
        #1;
        check_outputs(where);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = '0;
        out_ready   = '0;
        flush_spec  = 1'b0;
        commit_spec = 1'b0;
        clear       = 1'b0;
        for (int k = 0; k < W; k++) in_pkt[k] = ISSUE_IDLE;

        repeat (2) @(negedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill with pairs, no consumer: last push is dropped.
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            step("fill");
        end
        chk("fill.full_const", full, 1);
        chk("fill.in_ready_const", in_ready, 0);

        // Drain to 5, then reset in the middle of traffic.
        drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pop2");
        drive(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step("pop1");
        chk("pre_rst.count", count, 5);
        drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        q.delete();
        check_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;

        // Gapped valid vectors; then climb to 7 where in_ready must drop.
        drive(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("gap10");
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lane01");
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            step("odd_fill");
        end

        // Streaming across the index wrap.
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("clear1");
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            step("wrap_fill");
        end
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            step("wrap_stream");
        end

        // Flush: 3 untagged + 3 tagged, consumer takes 2 untagged.
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("clear2");
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("f_u2");
        drive(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("f_u1");
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("f_t2");
        drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("f_t1");
        drive(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("flush");
        chk("flush.count_const", count, 1);
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
            step("post_flush");
        end

        // Commit: 4 tagged, commit with 2 more tagged, then flush removes nothing.
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("clear3");
        for (int i = 0; i < 2; i++) begin
            drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
            step("c_t");
        end
        drive(2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        step("commit");
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("flush_after_commit");
        chk("commit.count_const", count, 6);
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            step("commit_drain");
        end

        // Random traffic; tagged packets only ever follow other tagged ones.
        spec_mode = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bit cl;
            bit fl;
            bit cm;
            bit tg;
            cl = ($urandom_range(0, 49) == 0);
            fl = !cl && ($urandom_range(0, 11) == 0);
            cm = !cl && !fl && ($urandom_range(0, 9) == 0);
            in_valid    = W'($urandom);
            out_ready   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            flush_spec  = fl;
            commit_spec = cm;
            clear       = cl;
            for (int k = 0; k < W; k++) begin
                tg = spec_mode || ($urandom_range(0, 5) == 0);
                if (tg) spec_mode = 1'b1;
                in_pkt[k] = rand_pkt(tg);
            end
            if (fl || cm || cl) spec_mode = 1'b0;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue_buffer.md
Name: instr_issue_buffer

Overview:
Parametrised multi-lane issue buffer between dispatch and the combo/ROB side. Accepts up to ISSUE_WIDTH decoded issue packets per cycle, holds them in an in-order circular store and presents up to ISSUE_WIDTH oldest packets per cycle under a valid/ready handshake. Adds speculation support: tagged (post-branch) entries are either committed (tag cleared) or flushed in one cycle. Also supports a synchronous full clear.

Parameters:
XLEN, 32, width of address and immediate fields
REG_W, 6, width of src_1/src_2/arn/rrn register indices
ISSUE_WIDTH, 2, lanes per cycle on input and output (1..4)
DEPTH, 8, entries; power of two, >= 2*ISSUE_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  ISSUE_WIDTH  per-lane push request from dispatch
in_pkt  in  ISSUE_WIDTH x issue_pkt_t  packets (address, immediate, src_1, src_2, arn, rrn, jump, tag, instr_name, st_type)
in_ready  out  1  buffer accepts a full group this cycle
out_valid  out  ISSUE_WIDTH  lane k holds the k-th oldest entry
out_pkt  out  ISSUE_WIDTH x issue_pkt_t  oldest entries, lane 0 oldest
out_ready  in  ISSUE_WIDTH  per-lane consumer acceptance
flush_spec  in  1  discard every entry with tag=1
commit_spec  in  1  clear tag of every stored entry
clear  in  1  synchronous empty
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: head=tail=0, count=0, spec_count=0, in_ready=1, out_valid=0, empty=1, full=0; out_pkt idle.
- Idle lane value (out_valid[k]=0): address/immediate/indices 0, jump/tag 0, instr_name UNKNOWN, st_type XX.
- in_ready = (DEPTH - count) >= ISSUE_WIDTH, from registered count (pops in same cycle not credited). Combinational from state only.
- Push: lanes accepted in order; lane k written only if in_valid[0..k] all 1 (first gap drops higher lanes). Nothing written when in_ready=0. Written at tail, tail += pushed, mod DEPTH. Write visible on outputs next cycle (1-cycle latency).
- Out: out_valid[k] = count > k; out_pkt[k] = entry at head+k mod DEPTH. Pop count = leading lanes with out_valid&out_ready; lane k popped only if lanes 0..k-1 popped. head += popped.
- Simultaneous push+pop: count_next = count + pushed - popped.
- spec_count tracks stored entries with tag=1; tagged entries are always the youngest contiguous block (dispatch guarantees).
- flush_spec: pushes that cycle ignored; out_valid forced 0 on lanes whose entry has tag=1; untagged pops proceed; tail_next = tail - spec_count; count_next = count - popped - spec_count; spec_count <= 0.
- commit_spec: all stored tags cleared, spec_count <= 0; packets pushed same cycle are stored with tag forced 0.
- flush_spec and commit_spec together: flush wins (assertion flags it).
- clear: highest priority after reset; head=tail=count=spec_count=0 next cycle, no push/pop effect that cycle.
- Wrap-around: all pointer arithmetic modulo DEPTH; pushes/pops spanning index DEPTH-1 -> 0 must be seamless.
- Assertions: count never > DEPTH; spec_count <= count; no out_ready-driven pop with out_valid=0.

Decomposition:
- Package instr_issue_pkg: issue_pkt_t packed struct, reuse of instr_name_e/st_type_e, ISSUE_IDLE constant for idle lane value.
- Sub-module issue_ring_store: DEPTH-entry storage with ISSUE_WIDTH write and read ports and a per-entry tag-clear vector; the top holds pointers, counters and control.

Test Plan:
- Reset mid-traffic (count=5) -> next edge count=0, empty=1, in_ready=1, all out_valid=0, out_pkt idle.
- W=2,D=8: push 2/cycle for 4 cycles, out_ready=0 -> count 8, full=1, in_ready=0 from count 7 onward; 5th push dropped.
- in_valid=2'b10 -> nothing written; in_valid=2'b01 -> 1 entry, out_valid=2'b01 next cycle.
- Fill 6, pop 2/cycle while pushing 2/cycle across index 7->0 -> order preserved, count stays 6.
- 3 untagged + 3 tagged stored, flush_spec with out_ready=2'b11 -> 2 untagged popped, count=1, tail moved back 3, spec_count=0.
- 4 tagged stored, commit_spec with push of 2 tagged -> all 6 read back tag=0; subsequent flush_spec removes nothing.
